// File: rtl/onehot_enc_stream.sv
// Streaming 4-bit index to 16-bit one-hot encoder with a single-entry output register,
// plus a running occupancy mask and a saturating unique-slot counter.
module onehot_enc_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_onehot,
    output logic        out_dup,
    output logic [15:0] mask,
    output logic [4:0]  count,
    output logic        full
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        accept, pop;
    logic [15:0] onehot_p0;
    logic        hit_p0;
    logic [15:0] mask_base_p0;
    logic [4:0]  count_base_p0;
    logic [15:0] onehot_p1;
    logic        dup_p1;

    function automatic logic [4:0] sat_inc(input logic [4:0] c, input logic inc);
        if (inc && (c != 5'd16))
            return c + 5'd1;
        return c;
    endfunction

    // stage p0: decode the index against the mask as it will look after any clr
    always_comb begin
        onehot_p0     = 16'h1 << in_idx;
        mask_base_p0  = clr ? 16'h0 : mask;
        count_base_p0 = clr ? 5'd0 : count;
        hit_p0        = mask_base_p0[in_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = HOLD;
                     else if (out_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // stage p1: registered result; cleared on a bare pop so the bus idles at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_p1 <= 16'h0;
            dup_p1    <= 1'b0;
        end else if (accept) begin
            onehot_p1 <= onehot_p0;
            dup_p1    <= hit_p0;
        end else if (pop) begin
            onehot_p1 <= 16'h0;
            dup_p1    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask  <= 16'h0;
            count <= 5'd0;
        end else if (accept) begin
            mask  <= mask_base_p0 | onehot_p0;
            count <= sat_inc(count_base_p0, !hit_p0);
        end else if (clr) begin
            mask  <= 16'h0;
            count <= 5'd0;
        end
    end

    assign out_onehot = onehot_p1;
    assign out_dup    = dup_p1;
    assign full       = (count == 5'd16);

endmodule

// File: tb/tb_onehot_enc_stream.sv
// Self-checking bench for onehot_enc_stream: directed test-plan scenarios plus
// randomized traffic compared against a slot-set reference model.
module tb_onehot_enc_stream;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_ready, out_valid, out_ready, out_dup, full;
    logic [3:0]  in_idx;
    logic [15:0] out_onehot, mask;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    // reference model: which slots are occupied, and the held result
    bit          seen [16];
    bit          m_valid;
    logic [15:0] m_onehot;
    bit          m_dup;

    onehot_enc_stream dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_dup(out_dup),
        .mask(mask), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        for (int k = 0; k < 16; k++) if (seen[k]) m[k] = 1'b1;
        return m;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < 16; k++) n += seen[k];
        return n;
    endfunction

    // Drive one cycle of inputs, check against the model mid-cycle, then advance both.
    task automatic cycle(input bit v, input int idx, input bit ordy, input bit c, input bit r);
        bit exp_ready, acc;
        in_valid  = v;
        in_idx    = 4'(idx);
        out_ready = ordy;
        clr       = c;
        rst       = r;
        #4;
        exp_ready = !m_valid || ordy;
        chk("out_valid",  out_valid,  m_valid);
        chk("out_onehot", out_onehot, m_onehot);
        chk("out_dup",    out_dup,    m_dup);
        chk("mask",       mask,       model_mask());
        chk("count",      count,      model_count());
        chk("full",       full,       model_count() == 16);
        chk("in_ready",   in_ready,   exp_ready);
        acc = v && exp_ready;
        if (r) begin
            foreach (seen[k]) seen[k] = 0;
            m_valid = 0; m_onehot = '0; m_dup = 0;
        end else begin
            if (c) foreach (seen[k]) seen[k] = 0;
            if (acc) begin
                m_dup       = seen[idx];
                seen[idx]   = 1;
                m_onehot    = 16'(32'd1 << idx);
                m_valid     = 1;
            end else if (m_valid && ordy) begin
                m_valid = 0; m_onehot = '0; m_dup = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; clr = 0; in_valid = 0; in_idx = '0; out_ready = 0;
        foreach (seen[k]) seen[k] = 0;
        m_valid = 0; m_onehot = '0; m_dup = 0;
        @(posedge clk); #1;
        cycle(0, 0, 1, 0, 1);
        rst = 0;
        #1;
        chk("rst_valid",  out_valid,  0);
        chk("rst_onehot", out_onehot, 0);
        chk("rst_mask",   mask,       0);
        chk("rst_count",  count,      0);
        chk("rst_ready",  in_ready,   1);

        for (int i = 0; i < 16; i++) begin
            cycle(1, i, 1, 0, 0);
            chk("seq_onehot", out_onehot, 32'd1 << i);
            chk("seq_dup",    out_dup,    0);
        end
        chk("seq_count", count, 16);
        chk("seq_full",  full,  1);
        chk("seq_mask",  mask,  16'hFFFF);

        // full: accept index 12 is a duplicate, count saturates
        cycle(1, 12, 1, 0, 0);
        chk("full_dup",    out_dup,    1);
        chk("full_onehot", out_onehot, 16'h1000);
        chk("full_count",  count,      16);

        // duplicate index 5
        cycle(0, 0, 1, 0, 1);
        cycle(1, 5, 1, 0, 0);
        cycle(1, 5, 1, 0, 0);
        chk("dup5_onehot", out_onehot, 16'h0020);
        chk("dup5_dup",    out_dup,    1);
        chk("dup5_count",  count,      1);
        chk("dup5_mask",   mask,       16'h0020);

        // backpressure: hold index 3 while index 9 waits
        cycle(0, 0, 1, 0, 1);
        cycle(1, 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 9, 0, 0, 0);
            chk("bp_onehot", out_onehot, 16'h0008);
            chk("bp_ready",  in_ready,   0);
        end
        cycle(1, 9, 1, 0, 0);
        chk("bp_pop_onehot", out_onehot, 16'h0200);
        chk("bp_pop_valid",  out_valid,  1);

        // clr with simultaneous accept of 7 while mask = 0x00FF
        cycle(0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, i, 1, 0, 0);
        chk("pre_clr_mask",  mask,  16'h00FF);
        chk("pre_clr_count", count, 8);
        cycle(1, 7, 1, 1, 0);
        chk("clr_mask",  mask,    16'h0080);
        chk("clr_count", count,   1);
        chk("clr_dup",   out_dup, 0);

        // rst while a result is held and input is pending
        cycle(1, 4, 0, 0, 0);
        chk("prerst_valid", out_valid, 1);
        cycle(1, 4, 0, 0, 1);
        chk("midrst_valid",  out_valid,  0);
        chk("midrst_onehot", out_onehot, 0);
        chk("midrst_dup",    out_dup,    0);
        chk("midrst_mask",   mask,       0);
        chk("midrst_count",  count,      0);
        chk("midrst_ready",  in_ready,   1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom % 4) != 0, $urandom_range(0, 15), ($urandom % 4) != 0,
                  ($urandom % 40) == 0, ($urandom % 150) == 0);
        end
        cycle(0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_enc_stream.md
# onehot_enc_stream

Streaming binary-to-one-hot encoder for the sort datapath. It accepts 4-bit slot indices over a valid/ready handshake and returns each one as a registered 16-bit one-hot select, one cycle later. It also keeps a running occupancy mask and a unique-slot counter, so the sorter can see when all 16 output slots are placed and which placements collided. This is the producer side of the one-hot select bus that the sort unit's one-hot-to-binary decoder consumes.

## Interface
- Parameters: none. Widths are fixed at 16 slots / 4-bit index to match the sort datapath.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of mask and count; does not touch the output register.
- in_valid  in  1  in_idx is valid.
- in_ready  out  1  block can accept in_idx this cycle (combinational).
- in_idx  in  4  slot index 0..15.
- out_valid  out  1  out_onehot/out_dup hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_onehot  out  16  1 << accepted in_idx.
- out_dup  out  1  accepted index was already set in mask when accepted.
- mask  out  16  OR of all one-hots accepted since the last rst/clr.
- count  out  5  number of distinct slots set in mask, 0..16.
- full  out  1  count == 16.

## Operation
- Output register is a single entry with two states:
  - EMPTY: out_valid = 0.
  - HOLD: out_valid = 1.
- in_ready = !out_valid || out_ready. Back-to-back streaming is allowed when the consumer holds out_ready high.
- Accept: a handshake is `accept = in_valid && in_ready`. On accept:
  - out_onehot <= 16'h1 << in_idx
  - out_dup <= mask[in_idx] (the pre-update mask)
  - out_valid <= 1
  - mask <= mask | onehot
  - count <= count + (mask[in_idx] ? 0 : 1)
- Pop without accept (out_valid && out_ready && !accept): out_valid <= 0, out_onehot <= 0, out_dup <= 0.
- Stall (out_valid && !out_ready): out_onehot, out_dup and out_valid hold. in_ready = 0.
- Transitions:
  - EMPTY -> HOLD on accept.
  - HOLD -> HOLD on accept (simultaneous pop + accept).
  - HOLD -> EMPTY on pop without accept.
- Full: accepts are still taken. Every index is then a duplicate, so out_dup = 1 and count stays at 16. count never exceeds 16 and never wraps.
- clr with no accept: mask <= 0, count <= 0.
- clr with accept in the same cycle: the accepted index is applied on top of the cleared state. mask <= onehot, count <= 1, out_dup <= 0.
- in_idx is a full 4-bit code; every value is legal, so no out-of-range case exists.

## Timing
- Reset values: out_valid = 0, out_onehot = 0, out_dup = 0, mask = 0, count = 0, full = 0. in_ready = 1 in the first cycle after rst deasserts.
- rst during operation overrides clr and any accept in that cycle. An in-flight result is dropped without a pop.
- Latency: one cycle from accept to out_valid/out_onehot.
- mask, count and full are registered and reflect accepts up to and including the previous edge.
- Throughput: one index per cycle with out_ready held high.
- in_idx may change freely while in_valid = 0. The consumer must not depend on out_onehot while out_valid = 0 (it reads 0 after a pop).

## Test plan
- Reset, then indices 0..15 in consecutive cycles with out_ready = 1:
  - out_onehot = 0x0001, 0x0002 … 0x8000, each one cycle after its accept.
  - out_dup always 0.
  - count reaches 16, full = 1, mask = 0xFFFF.
- Index 5, then index 5 again:
  - Second result out_onehot = 0x0020, out_dup = 1.
  - count stays 1, mask = 0x0020.
- Backpressure: accept index 3, hold out_ready = 0 for 4 cycles while in_valid = 1 with index 9:
  - in_ready = 0 and out_onehot stays 0x0008 throughout.
  - Raise out_ready: 0x0008 pops and index 9 is accepted in the same cycle; next cycle out_onehot = 0x0200.
- clr with a simultaneous accept of index 7 while mask = 0x00FF, count = 8:
  - Next cycle mask = 0x0080, count = 1, out_dup = 0.
- When full, accept index 12:
  - out_dup = 1, count stays 16, no wrap.
- Assert rst while out_valid = 1 and in_valid = 1:
  - Next cycle all outputs are at reset values and in_ready = 1.
